// File: rtl/text_console_if.sv
// Character-stream input and display-buffer write port bundle for text_console.
// RW/CW must match the console's $clog2(GRID_ROW)/$clog2(GRID_COL).
interface text_console_if #(
    parameter int RW = 3,
    parameter int CW = 4
);
    logic          char_valid;
    logic [7:0]    char_data;
    logic          char_ready;
    logic          attr_we;
    logic [7:0]    attr_data;
    logic          buffer_we;
    logic [31:0]   buffer_addr;
    logic [31:0]   buffer_data;
    logic [RW-1:0] cursor_row;
    logic [CW-1:0] cursor_col;

    modport master (
        output char_valid, char_data, attr_we, attr_data,
        input  char_ready, buffer_we, buffer_addr, buffer_data, cursor_row, cursor_col
    );

    modport slave (
        input  char_valid, char_data, attr_we, attr_data,
        output char_ready, buffer_we, buffer_addr, buffer_data, cursor_row, cursor_col
    );
endinterface

// File: rtl/text_console.sv
// Text console front end: byte stream -> cursor/attr tracking -> display buffer writes.
// Optional `TEXT_CONSOLE_ESC_ATTR_EN: ESC (0x1B) loads the following byte as the attribute.
module text_console #(
    parameter int         GRID_ROW     = 5,
    parameter int         GRID_COL     = 10,
    parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
    input  logic          clk_pix,
    input  logic          rst_n,
    text_console_if.slave bus
);
    localparam int              RW          = (GRID_ROW > 1) ? $clog2(GRID_ROW) : 1;
    localparam int              CW          = (GRID_COL > 1) ? $clog2(GRID_COL) : 1;
    localparam logic [RW-1:0]   ROW_LAST    = RW'(GRID_ROW - 1);
    localparam logic [CW-1:0]   COL_LAST    = CW'(GRID_COL - 1);
    localparam logic [31:0]     SCREEN_LAST = 32'(GRID_ROW * GRID_COL - 1);
    localparam logic [31:0]     LINE_LAST   = 32'(GRID_COL - 1);
    localparam logic [7:0]      SPACE       = 8'h20;

`ifdef TEXT_CONSOLE_ESC_ATTR_EN
    typedef enum logic [1:0] {CLR_SCREEN, CLR_LINE, IDLE, ESC_WAIT} state_t;
`else
    typedef enum logic [1:0] {CLR_SCREEN, CLR_LINE, IDLE} state_t;
`endif

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    attr_q, attr_d;
    logic [31:0]   clr_addr_q, clr_addr_d;
    logic [31:0]   clr_last_q, clr_last_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;

    logic          xfer, adv_row, start_clr;
    state_t        clr_state;
    logic [31:0]   clr_last, cur_addr;
    logic [7:0]    ch;

    assign ch       = bus.char_data;
    assign cur_addr = 32'(row_q) * 32'(GRID_COL) + 32'(col_q);

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLR_SCREEN;
            row_q      <= '0;
            col_q      <= '0;
            attr_q     <= DEFAULT_ATTR;
            clr_addr_q <= '0;
            clr_last_q <= SCREEN_LAST;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            attr_q     <= attr_d;
            clr_addr_q <= clr_addr_d;
            clr_last_q <= clr_last_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        attr_d     = attr_q;
        clr_addr_d = clr_addr_q;
        clr_last_d = clr_last_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        adv_row    = 1'b0;
        start_clr  = 1'b0;
        clr_state  = CLR_LINE;
        clr_last   = LINE_LAST;
        xfer       = bus.char_valid && ready_q;

        case (state_q)
            CLR_SCREEN, CLR_LINE: begin
                we_d       = 1'b1;
                addr_d     = clr_addr_q;
                data_d     = {16'h0, attr_q, SPACE};
                clr_addr_d = clr_addr_q + 32'd1;
                if (clr_addr_q == clr_last_q) state_d = IDLE;
            end
            IDLE: begin
                if (xfer) begin
                    if (ch >= 8'h20 && ch <= 8'h7E) begin
                        we_d   = 1'b1;
                        addr_d = cur_addr;
                        data_d = {16'h0, attr_q, ch};
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            adv_row = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        case (ch)
                            8'h0A: begin
                                col_d   = '0;
                                adv_row = 1'b1;
                            end
                            8'h0D: col_d = '0;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d  = col_q - 1'b1;
                                    we_d   = 1'b1;
                                    addr_d = cur_addr - 32'd1;
                                    data_d = {16'h0, attr_q, SPACE};
                                end
                            end
                            8'h0C: begin
                                row_d     = '0;
                                col_d     = '0;
                                start_clr = 1'b1;
                                clr_state = CLR_SCREEN;
                                clr_last  = SCREEN_LAST;
                            end
`ifdef TEXT_CONSOLE_ESC_ATTR_EN
                            8'h1B: state_d = ESC_WAIT;
`endif
                            default: ;
                        endcase
                    end
                end
            end
`ifdef TEXT_CONSOLE_ESC_ATTR_EN
            ESC_WAIT: begin
                if (xfer) begin
                    attr_d  = ch;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (adv_row) begin
            if (row_q == ROW_LAST) begin
                row_d     = '0;
                start_clr = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end

        // A clear begins on the transfer edge itself unless that edge already writes a character.
        if (start_clr) begin
            clr_last_d = clr_last;
            if (we_d) begin
                clr_addr_d = '0;
                state_d    = clr_state;
            end else begin
                we_d       = 1'b1;
                addr_d     = '0;
                data_d     = {16'h0, attr_q, SPACE};
                clr_addr_d = 32'd1;
                state_d    = (clr_last == '0) ? IDLE : clr_state;
            end
        end

        if (bus.attr_we) attr_d = bus.attr_data;

`ifdef TEXT_CONSOLE_ESC_ATTR_EN
        ready_d = !start_clr && (state_q inside {IDLE, ESC_WAIT}) && (state_d inside {IDLE, ESC_WAIT});
`else
        ready_d = !start_clr && (state_q == IDLE) && (state_d == IDLE);
`endif
    end

    assign bus.char_ready  = ready_q;
    assign bus.buffer_we   = we_q;
    assign bus.buffer_addr = addr_q;
    assign bus.buffer_data = data_q;
    assign bus.cursor_row  = row_q;
    assign bus.cursor_col  = col_q;
endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: a character model queues expected buffer writes,
// a monitor pops them as the DUT writes; scenario tasks add direct checks.
module tb_text_console;
    localparam int GRID_ROW = 5;
    localparam int GRID_COL = 10;
    localparam int RW = $clog2(GRID_ROW);
    localparam int CW = $clog2(GRID_COL);

    logic clk_pix = 1'b0;
    logic rst_n   = 1'b1;
    always #5 clk_pix = ~clk_pix;

    text_console_if #(.RW(RW), .CW(CW)) bus();

    text_console #(.GRID_ROW(GRID_ROW), .GRID_COL(GRID_COL), .DEFAULT_ATTR(8'h0F)) dut (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    int          m_row  = 0;
    int          m_col  = 0;
    logic [7:0]  m_attr = 8'h0F;
    bit          m_esc  = 1'b0;

    always @(posedge clk_pix) begin
        #1;
        if (bus.buffer_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected addr=%0d data=%h, none expected", bus.buffer_addr, bus.buffer_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.buffer_addr, bus.buffer_data} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             bus.buffer_addr, bus.buffer_data, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic push_exp(input int addr, input logic [7:0] attr, input logic [7:0] c);
        exp_q.push_back({32'(addr), 16'h0, attr, c});
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit adv;
        adv = 1'b0;
`ifdef TEXT_CONSOLE_ESC_ATTR_EN
        if (m_esc) begin
            m_attr = b;
            m_esc  = 1'b0;
            return;
        end
`endif
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_exp(m_row * GRID_COL + m_col, m_attr, b);
            if (m_col == GRID_COL - 1) begin m_col = 0; adv = 1'b1; end
            else m_col++;
        end else if (b == 8'h0A) begin
            m_col = 0; adv = 1'b1;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_exp(m_row * GRID_COL + m_col, m_attr, 8'h20);
            end
        end else if (b == 8'h0C) begin
            m_row = 0; m_col = 0;
            for (int i = 0; i < GRID_ROW * GRID_COL; i++) push_exp(i, m_attr, 8'h20);
        end
`ifdef TEXT_CONSOLE_ESC_ATTR_EN
        else if (b == 8'h1B) m_esc = 1'b1;
`endif
        if (adv) begin
            if (m_row == GRID_ROW - 1) begin
                m_row = 0;
                for (int i = 0; i < GRID_COL; i++) push_exp(i, m_attr, 8'h20);
            end else m_row++;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (bus.char_ready !== 1'b1 && n < 300) begin @(negedge clk_pix); n++; end
        ok = (bus.char_ready === 1'b1);
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout ready=%b expected 1", bus.char_ready);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        @(negedge clk_pix);
        wait_ready(ok);
        if (!ok) return;
        bus.char_valid = 1'b1;
        bus.char_data  = b;
        model_byte(b);
        @(negedge clk_pix);
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(negedge clk_pix); n++; end
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_attr(input logic [7:0] a);
        @(negedge clk_pix);
        bus.attr_we = 1'b1; bus.attr_data = a; m_attr = a;
        @(negedge clk_pix);
        bus.attr_we = 1'b0;
    endtask

    task automatic clear_screen();
        send_byte(8'h0C);
        wait_drain(200);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        vectors++; if (bus.buffer_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%b expected 0", bus.buffer_we); end
        vectors++; if (bus.buffer_addr !== 32'd0) begin miscompares++; $display("FAIL rst_addr got=%h expected 0", bus.buffer_addr); end
        vectors++; if (bus.buffer_data !== 32'd0) begin miscompares++; $display("FAIL rst_data got=%h expected 0", bus.buffer_data); end
        vectors++; if (bus.char_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b expected 0", bus.char_ready); end
        vectors++; if (bus.cursor_row !== 3'd0 || bus.cursor_col !== 4'd0) begin
            miscompares++; $display("FAIL rst_cursor got=%0d,%0d expected 0,0", bus.cursor_row, bus.cursor_col); end
        for (int i = 0; i < GRID_ROW * GRID_COL; i++) push_exp(i, 8'h0F, 8'h20);
        @(negedge clk_pix);
        rst_n = 1'b1;
        wait_drain(200);
        vectors++; if (bus.char_ready !== 1'b0) begin miscompares++; $display("FAIL ready_at_last_clear got=%b expected 0", bus.char_ready); end
        @(negedge clk_pix);
        vectors++; if (bus.char_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_clear got=%b expected 1", bus.char_ready); end

        // reset in the middle of a screen clear
        send_byte(8'h0C);
        repeat (5) @(negedge clk_pix);
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.buffer_we !== 1'b0 || bus.char_ready !== 1'b0 || bus.buffer_addr !== 32'd0) begin
            miscompares++; $display("FAIL midclear_rst got we=%b ready=%b addr=%0d expected 0,0,0",
                                    bus.buffer_we, bus.char_ready, bus.buffer_addr); end
        exp_q.delete();
        m_row = 0; m_col = 0; m_attr = 8'h0F; m_esc = 1'b0;
        for (int i = 0; i < GRID_ROW * GRID_COL; i++) push_exp(i, 8'h0F, 8'h20);
        @(negedge clk_pix);
        rst_n = 1'b1;
        wait_drain(200);
    endtask

    task automatic test_printable();
        clear_screen();
        send_byte(8'h41);
        vectors++; if (bus.buffer_we !== 1'b1 || bus.buffer_addr !== 32'd0 || bus.buffer_data !== 32'h0000_0F41) begin
            miscompares++; $display("FAIL print_latency got we=%b addr=%0d data=%h expected 1,0,00000f41",
                                    bus.buffer_we, bus.buffer_addr, bus.buffer_data); end
        vectors++; if (bus.cursor_col !== 4'd1) begin miscompares++; $display("FAIL print_col got=%0d expected 1", bus.cursor_col); end
        wait_drain(10);
    endtask

    task automatic test_line_wrap();
        clear_screen();
        for (int i = 0; i < 11; i++) send_byte(8'h30 + 8'(i));
        wait_drain(20);
        vectors++; if (bus.cursor_row !== 3'd1 || bus.cursor_col !== 4'd1) begin
            miscompares++; $display("FAIL wrap_cursor got=%0d,%0d expected 1,1", bus.cursor_row, bus.cursor_col); end
    endtask

    task automatic test_lf_wrap_top();
        int n;
        clear_screen();
        repeat (4) send_byte(8'h0A);
        send_byte(8'h78); send_byte(8'h79); send_byte(8'h7A);
        wait_drain(20);
        vectors++; if (bus.cursor_row !== 3'd4 || bus.cursor_col !== 4'd3) begin
            miscompares++; $display("FAIL lf_setup_cursor got=%0d,%0d expected 4,3", bus.cursor_row, bus.cursor_col); end
        send_byte(8'h0A);
        n = 0;
        while (bus.char_ready !== 1'b1 && n < 40) begin n++; @(negedge clk_pix); end
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL lf_ready_low_cycles got=%0d expected 10", n); end
        wait_drain(20);
        vectors++; if (bus.cursor_row !== 3'd0 || bus.cursor_col !== 4'd0) begin
            miscompares++; $display("FAIL lf_cursor got=%0d,%0d expected 0,0", bus.cursor_row, bus.cursor_col); end
    endtask

    task automatic test_backspace();
        clear_screen();
        send_byte(8'h0A); send_byte(8'h0A);
        send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
        send_byte(8'h08);
        vectors++; if (bus.buffer_we !== 1'b1 || bus.buffer_addr !== 32'd22 || bus.buffer_data !== 32'h0000_0F20) begin
            miscompares++; $display("FAIL bs_write got we=%b addr=%0d data=%h expected 1,22,00000f20",
                                    bus.buffer_we, bus.buffer_addr, bus.buffer_data); end
        vectors++; if (bus.cursor_col !== 4'd2) begin miscompares++; $display("FAIL bs_col got=%0d expected 2", bus.cursor_col); end
        send_byte(8'h0D);
        vectors++; if (bus.buffer_we !== 1'b0 || bus.cursor_col !== 4'd0) begin
            miscompares++; $display("FAIL cr got we=%b col=%0d expected 0,0", bus.buffer_we, bus.cursor_col); end
        send_byte(8'h08);
        vectors++; if (bus.buffer_we !== 1'b0 || bus.cursor_col !== 4'd0 || bus.cursor_row !== 3'd2) begin
            miscompares++; $display("FAIL bs_col0 got we=%b row=%0d col=%0d expected 0,2,0",
                                    bus.buffer_we, bus.cursor_row, bus.cursor_col); end
        wait_drain(10);
    endtask

    task automatic test_escape();
        clear_screen();
        send_byte(8'h1B); send_byte(8'h4E); send_byte(8'h42);
`ifdef TEXT_CONSOLE_ESC_ATTR_EN
        vectors++; if (bus.buffer_addr !== 32'd0 || bus.buffer_data !== 32'h0000_4E42 || bus.cursor_col !== 4'd1) begin
            miscompares++; $display("FAIL esc got addr=%0d data=%h col=%0d expected 0,00004e42,1",
                                    bus.buffer_addr, bus.buffer_data, bus.cursor_col); end
        send_byte(8'h1B); send_byte(8'h0F);
`else
        vectors++; if (bus.buffer_addr !== 32'd1 || bus.buffer_data !== 32'h0000_0F42 || bus.cursor_col !== 4'd2) begin
            miscompares++; $display("FAIL esc_off got addr=%0d data=%h col=%0d expected 1,00000f42,2",
                                    bus.buffer_addr, bus.buffer_data, bus.cursor_col); end
`endif
        wait_drain(10);
    endtask

    task automatic test_attr_and_ignored();
        bit ok;
        logic [7:0] ign [4];
        ign = '{8'h00, 8'h1F, 8'h7F, 8'hFF};
        clear_screen();
        @(negedge clk_pix);
        wait_ready(ok);
        if (ok) begin
            bus.char_valid = 1'b1; bus.char_data = 8'h43;
            bus.attr_we = 1'b1; bus.attr_data = 8'h2A;
            push_exp(0, 8'h0F, 8'h43); m_col = 1; m_attr = 8'h2A;
            @(negedge clk_pix);
            bus.char_valid = 1'b0; bus.attr_we = 1'b0;
            vectors++; if (bus.buffer_data !== 32'h0000_0F43) begin
                miscompares++; $display("FAIL attr_same_edge got=%h expected 00000f43", bus.buffer_data); end
        end
        send_byte(8'h44);
        vectors++; if (bus.buffer_data !== 32'h0000_2A44) begin
            miscompares++; $display("FAIL attr_new got=%h expected 00002a44", bus.buffer_data); end
        pulse_attr(8'h0F);
        foreach (ign[i]) begin
            send_byte(ign[i]);
            vectors++; if (bus.buffer_we !== 1'b0 || bus.char_ready !== 1'b1) begin
                miscompares++; $display("FAIL ignored byte=%h got we=%b ready=%b expected 0,1",
                                        ign[i], bus.buffer_we, bus.char_ready); end
        end
        wait_drain(10);
    endtask

    task automatic test_attr_during_clear();
        bit ok;
        clear_screen();
        @(negedge clk_pix);
        wait_ready(ok);
        if (!ok) return;
        bus.char_valid = 1'b1; bus.char_data = 8'h0C;
        push_exp(0, 8'h0F, 8'h20); push_exp(1, 8'h0F, 8'h20);
        for (int i = 2; i < GRID_ROW * GRID_COL; i++) push_exp(i, 8'h1F, 8'h20);
        m_row = 0; m_col = 0; m_attr = 8'h1F;
        @(negedge clk_pix);
        bus.char_valid = 1'b0;
        bus.attr_we = 1'b1; bus.attr_data = 8'h1F;
        @(negedge clk_pix);
        bus.attr_we = 1'b0;
        wait_drain(200);
        pulse_attr(8'h0F);
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_screen();
        @(negedge clk_pix);
        wait_ready(ok);
        if (!ok) return;
        for (int i = 0; i < GRID_COL; i++) begin
            bus.char_valid = 1'b1; bus.char_data = 8'h61 + 8'(i);
            model_byte(8'h61 + 8'(i));
            @(negedge clk_pix);
            vectors++; if (bus.char_ready !== 1'b1) begin
                miscompares++; $display("FAIL b2b_ready idx=%0d got=%b expected 1", i, bus.char_ready); end
        end
        bus.char_valid = 1'b0;
        wait_drain(20);
        vectors++; if (bus.cursor_row !== 3'd1 || bus.cursor_col !== 4'd0) begin
            miscompares++; $display("FAIL b2b_cursor got=%0d,%0d expected 1,0", bus.cursor_row, bus.cursor_col); end
    endtask

    initial begin
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        bus.attr_we    = 1'b0;
        bus.attr_data  = 8'h00;
        test_reset();
        test_printable();
        test_line_wrap();
        test_lf_wrap_top();
        test_backspace();
        test_escape();
        test_attr_and_ignored();
        test_attr_during_clear();
        test_back_to_back();
        repeat (3) @(negedge clk_pix);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
